// File: rtl/button_pulse_gen_if.sv
// Button front-end bus: raw board buttons in, one-cycle pulses and
// debounced levels out. The slave side is the pulse generator, the
// master side is whatever owns the buttons (board pins or a bench).
// Raw inputs are asynchronous and active-high. Each pulse output is
// registered and lasts exactly one clock; at most one is high per cycle.
interface button_pulse_gen_if;
   logic       up_raw;
   logic       left_raw;
   logic       right_raw;
   logic       conf_raw;
   logic       up_o;
   logic       left_o;
   logic       right_o;
   logic       confirm_o;
   logic [3:0] level_o;

   modport slave (
      input  up_raw, left_raw, right_raw, conf_raw,
      output up_o, left_o, right_o, confirm_o, level_o
   );

   modport master (
      output up_raw, left_raw, right_raw, conf_raw,
      input  up_o, left_o, right_o, confirm_o, level_o
   );
endinterface

// File: rtl/button_pulse_gen.sv
// Four-button front end for the mode/state shifter.
// Per button: 2-FF synchroniser -> debounce filter -> rising-edge event.
// Left/right add auto-repeat while held. A fixed-priority arbiter
// (up > left > right > confirm) drains one pending event per cycle so
// the shifter never sees two pulses in the same cycle.
// Bit order everywhere: [3]=up, [2]=left, [1]=right, [0]=confirm.
module button_pulse_gen #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter logic [26:0] REPEAT_DELAY    = 27'd50_000_000,
   parameter logic [26:0] REPEAT_PERIOD   = 27'd10_000_000
) (
   input logic               clk,
   input logic               rst,
   button_pulse_gen_if.slave bus
);

   localparam int DW = $clog2(int'(DEBOUNCE_CYCLES));
   localparam int HW = $clog2(int'(REPEAT_DELAY) + int'(REPEAT_PERIOD) + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 20'd1);
   localparam logic [HW-1:0] RD_H     = HW'(REPEAT_DELAY);
   // Last hold count before the next repeat; the counter then folds back
   // to REPEAT_DELAY so it never needs to count past one period.
   localparam logic [HW-1:0] WRAP_H   = HW'(int'(REPEAT_DELAY) + int'(REPEAT_PERIOD) - 1);

   logic [3:0]    raw;
   logic [3:0]    s1_q, s1_d, s2_q, s2_d;
   logic [3:0]    stable_q, stable_d, prev_q, prev_d;
   logic [3:0]    pend_q, pend_d, pulse_q, pulse_d;
   logic [3:0]    ev, grant;
   logic [DW-1:0] cnt_q [4];
   logic [DW-1:0] cnt_d [4];
   logic [HW-1:0] hold_q [2];   // [0]=right, [1]=left
   logic [HW-1:0] hold_d [2];

   assign raw = {bus.up_raw, bus.left_raw, bus.right_raw, bus.conf_raw};

   // Synchronise raw inputs and accept a level change only after
   // DEBOUNCE_CYCLES consecutive cycles of disagreement.
   always_comb begin
      s1_d     = raw;
      s2_d     = s1_q;
      prev_d   = stable_q;
      stable_d = stable_q;
      for (int b = 0; b < 4; b++) begin
         cnt_d[b] = '0;
         if (s2_q[b] != stable_q[b]) begin
            if (cnt_q[b] == DEB_LAST) begin
               stable_d[b] = s2_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + DW'(1);
            end
         end
      end
   end

   // Press events from stable rising edges, plus auto-repeat events on
   // left/right from the hold counters.
   always_comb begin
      ev = stable_q & ~prev_q;
      for (int h = 0; h < 2; h++) begin
         hold_d[h] = '0;
         if (REPEAT_EN && stable_q[h+1]) begin
            if (hold_q[h] == WRAP_H) begin
               hold_d[h] = RD_H;
            end else begin
               hold_d[h] = hold_q[h] + HW'(1);
            end
            if (hold_q[h] == RD_H) begin
               ev[h+1] = 1'b1;
            end
         end
      end
   end

   // Issue the highest-priority pending event; a fresh event on the bit
   // being issued keeps it set so one more pulse follows.
   always_comb begin
      grant = 4'b0000;
      if (pend_q[3]) begin
         grant = 4'b1000;
      end else if (pend_q[2]) begin
         grant = 4'b0100;
      end else if (pend_q[1]) begin
         grant = 4'b0010;
      end else if (pend_q[0]) begin
         grant = 4'b0001;
      end
      pend_d  = (pend_q & ~grant) | ev;
      pulse_d = grant;
   end

   // State registers; reset discards everything including pending events.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         prev_q   <= '0;
         pend_q   <= '0;
         pulse_q  <= '0;
         for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
         for (int h = 0; h < 2; h++) hold_q[h] <= '0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         stable_q <= stable_d;
         prev_q   <= prev_d;
         pend_q   <= pend_d;
         pulse_q  <= pulse_d;
         for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
         for (int h = 0; h < 2; h++) hold_q[h] <= hold_d[h];
      end
   end

   assign bus.up_o      = pulse_q[3];
   assign bus.left_o    = pulse_q[2];
   assign bus.right_o   = pulse_q[1];
   assign bus.confirm_o = pulse_q[0];
   assign bus.level_o   = stable_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. A second instance with REPEAT_EN=0
// shares the same raw inputs. Expected pulses are queued as
// {cycle[27:0], code[3:0]} and matched as the DUT emits them.
module tb_button_pulse_gen;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   button_pulse_gen_if bus0 ();
   button_pulse_gen_if bus1 ();

   assign bus1.up_raw    = bus0.up_raw;
   assign bus1.left_raw  = bus0.left_raw;
   assign bus1.right_raw = bus0.right_raw;
   assign bus1.conf_raw  = bus0.conf_raw;

   button_pulse_gen #(
      .DEBOUNCE_CYCLES(20'd4), .REPEAT_EN(1'b1),
      .REPEAT_DELAY(27'd20), .REPEAT_PERIOD(27'd8)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus0)
   );

   button_pulse_gen #(
      .DEBOUNCE_CYCLES(20'd4), .REPEAT_EN(1'b0),
      .REPEAT_DELAY(27'd20), .REPEAT_PERIOD(27'd8)
   ) dut_norep (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   // Clock
   always #5 clk = ~clk;

   logic [31:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int norep_right = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int c, input logic [3:0] code);
      exp_q.push_back({c[27:0], code});
   endtask

   // Advance n clock edges; after each edge check the one-hot invariant
   // and match any pulse against the scoreboard.
   task automatic step(input int n);
      logic [3:0]  p;
      logic [31:0] e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         #1;
         p = {bus0.up_o, bus0.left_o, bus0.right_o, bus0.confirm_o};
         if (bus1.right_o) norep_right++;
         n_tests++;
         assert ($countones(p) <= 1) else begin
            n_fail++;
            $error("FAIL onehot: got %b expected at most one bit at cycle %0d", p, cyc);
         end
         if (p != 4'b0000) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $error("FAIL pulse: got code %b at cycle %0d expected no pulse", p, cyc);
            end else begin
               e = exp_q.pop_front();
               assert ({cyc[27:0], p} === e) else begin
                  n_fail++;
                  $error("FAIL pulse: got cycle %0d code %b expected cycle %0d code %b",
                         cyc, p, e[31:4], e[3:0]);
               end
            end
         end
      end
   endtask

   initial begin
      int k;
      int r;
      bus0.up_raw = 1'b0; bus0.left_raw = 1'b0;
      bus0.right_raw = 1'b0; bus0.conf_raw = 1'b0;

      // Reset state
      step(3);
      chk("rst_pulses", {28'd0, bus0.up_o, bus0.left_o, bus0.right_o, bus0.confirm_o}, 32'd0);
      chk("rst_level", {28'd0, bus0.level_o}, 32'd0);
      rst = 1'b1;
      step(10);

      // 1: single left press, level and pulse timing
      k = cyc;
      bus0.left_raw = 1'b1;
      push(k + D + 4, 4'b0100);
      step(D + 1);
      chk("t1_level_before", {28'd0, bus0.level_o}, 32'd0);
      step(1);
      chk("t1_level_after", {28'd0, bus0.level_o}, 32'h4);
      step(4);
      bus0.left_raw = 1'b0;
      step(7);
      chk("t1_level_release", {28'd0, bus0.level_o}, 32'd0);
      step(5);
      chk("t1_queue", exp_q.size(), 32'd0);

      // 2: 3-cycle confirm glitch is rejected
      bus0.conf_raw = 1'b1;
      step(3);
      bus0.conf_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("t2_level", {28'd0, bus0.level_o}, 32'd0);
      end
      chk("t2_queue", exp_q.size(), 32'd0);

      // 3: right held 50 cycles -> press + 4 repeats; no-repeat instance -> 1
      r = norep_right;
      k = cyc;
      bus0.right_raw = 1'b1;
      push(k + 8, 4'b0010);
      push(k + 28, 4'b0010);
      push(k + 36, 4'b0010);
      push(k + 44, 4'b0010);
      push(k + 52, 4'b0010);
      step(50);
      bus0.right_raw = 1'b0;
      step(15);
      chk("t3_queue", exp_q.size(), 32'd0);
      chk("t3_norep_count", norep_right - r, 32'd1);

      // 4: up, left, confirm together -> three consecutive pulses by priority
      k = cyc;
      bus0.up_raw = 1'b1; bus0.left_raw = 1'b1; bus0.conf_raw = 1'b1;
      push(k + 8, 4'b1000);
      push(k + 9, 4'b0100);
      push(k + 10, 4'b0001);
      step(7);
      chk("t4_level", {28'd0, bus0.level_o}, 32'hd);
      step(3);
      bus0.up_raw = 1'b0; bus0.left_raw = 1'b0; bus0.conf_raw = 1'b0;
      step(15);
      chk("t4_queue", exp_q.size(), 32'd0);

      // 5: reset before the pulse is due discards it
      bus0.left_raw = 1'b1;
      step(5);
      rst = 1'b0;
      bus0.left_raw = 1'b0;
      step(2);
      rst = 1'b1;
      step(20);
      chk("t5_level", {28'd0, bus0.level_o}, 32'd0);
      chk("t5_queue", exp_q.size(), 32'd0);

      // 6: left held through reset -> fresh press after release
      bus0.left_raw = 1'b1;
      step(5);
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      r = cyc;
      push(r + D + 4, 4'b0100);
      step(15);
      bus0.left_raw = 1'b0;
      step(15);
      chk("t6_queue", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
